shift_right_seq: RTL and testbench
==================================

Name: shift_right_seq

Overview:
- Sequential lane shifter that moves a 96-bit word (8 lanes × 12 bits) right by 0..5 lanes and fills the vacated top lanes with a 12-bit fill value.
- It shifts one lane per cycle and has valid/ready handshakes on both the input and output sides.
- It undoes the datapath's existing combinational left lane shifter and is used on the unpack/return path of the same 96-bit lane bus.
- Its legal shift range matches the left shifter: 0..5 valid, 6..7 flagged invalid.

Parameters:
- LANE_W, 12, bits per lane
- LANES, 8, lanes per word (data width = LANE_W*LANES = 96)
- SHIFT_W, 3, width of shift amount
- MAX_SHIFT, 5, largest legal shift; larger values raise out_err

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word/shift/fill presented
- in_ready  output  1  block can accept a new request
- in  input  96  data word; lane k = in[12k+11:12k]
- shift  input  3  right shift amount in lanes
- fill  input  12  value written into each vacated top lane
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out  output  96  shifted result
- out_err  output  1  request had shift > MAX_SHIFT; qualified by out_valid

Behaviour:
- Reset (rst_n low, asynchronous):
  - state <= IDLE; data register, count, fill register, out_err all <= 0.
  - out_valid = 0 and out = 0 while in reset.
  - Reset mid-operation aborts the request with no output.
- States: IDLE, SHIFT, DONE. Fixed encoding.
- in_ready = 1 only in IDLE (combinational from state). No new request is taken while SHIFT or DONE is active.
- IDLE, on accept (in_valid & in_ready):
  - Capture in into the data register, shift into count, fill into the fill register.
  - If shift > MAX_SHIFT: out_err <= 1, data register holds in unchanged, next state DONE.
  - Else if shift == 0: out_err <= 0, next state DONE.
  - Else: out_err <= 0, next state SHIFT.
- SHIFT, every cycle:
  - data <= {fill_reg, data[95:12]}, i.e. lane k takes lane k+1 and lane 7 takes fill_reg.
  - count <= count - 1.
  - When count == 1 this cycle, next state is DONE.
- DONE:
  - out_valid = 1; out = data register; out_err as captured.
  - out and out_err hold stable until out_ready.
  - On out_valid & out_ready, next state is IDLE.
  - The earliest next accept is in the cycle after the output handshake.
- Latency, with the accept in cycle T:
  - out_valid is first high in cycle T+1+shift for a legal shift.
  - out_valid is first high in cycle T+1 for an illegal shift.
- Result for a legal shift s: out lane k = in lane k+s for k < 8-s; out lane k = fill for k >= 8-s.
- in, shift and fill are sampled only at accept; later changes are ignored.
- out_ready is ignored outside DONE.
- in_valid held high while the block is busy causes no effect until IDLE.
- out is driven from the data register in all states, but is meaningful only when out_valid = 1.

Test Plan:
- Legal shift: in lanes 7..0 = 0x008,0x007,...,0x001, shift=2, fill=0xABC, out_ready=1.
  - out lanes 7..0 = 0xABC,0xABC,0x008,0x007,0x006,0x005,0x004,0x003.
  - out_err=0; out_valid rises 3 cycles after accept.
- Zero and maximum shift: same in, shift=0.
  - out == in; out_valid at T+1.
  - Then shift=5, fill=0x00F: out lanes 7..0 = 0x00F ×5, 0x008, 0x007, 0x006; out_valid at T+6.
- Illegal shift: shift=6, in=0x123456789ABCDEF012345678.
  - out_valid at T+1, out_err=1, out equals in unchanged.
  - Repeat with shift=7 for the same result.
- Backpressure: shift=1, out_ready held 0 for 4 cycles after out_valid.
  - out, out_err and out_valid remain stable; in_ready stays 0.
  - Raising out_ready completes the handshake; in_ready=1 the next cycle.
- Reset mid-SHIFT: shift=5, deassert rst_n two cycles after accept.
  - out_valid=0 and out=0 immediately (asynchronously).
  - After release: in_ready=1, and the next request (shift=1) completes correctly with no residue from the aborted one.
- Back-to-back: a stream of 4 requests with random legal shifts, in_valid held high.
  - Each is accepted only in IDLE; the results match the reference formula in order.

Source files
------------

// File: rtl/shift_right_seq.sv
// Sequential right lane shifter: moves a lane word right one lane per cycle,
// back-filling the top lane, with valid/ready handshakes on both sides.
module shift_right_seq #(
    parameter int LANE_W    = 12,
    parameter int LANES     = 8,
    parameter int SHIFT_W   = 3,
    parameter int MAX_SHIFT = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANE_W*LANES-1:0]   in,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic [LANE_W-1:0]         fill,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W*LANES-1:0]   out,
    output logic                      out_err
);

    localparam int DATA_W = LANE_W * LANES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [DATA_W-1:0]   data_reg;
    logic [DATA_W-1:0]   data_shifted;
    logic [SHIFT_W-1:0]  count_reg;
    logic [LANE_W-1:0]   fill_reg;
    logic                err_reg;
    logic                accept;
    logic                shift_illegal;

    assign accept        = in_valid && (state_reg == IDLE);
    assign shift_illegal = shift > SHIFT_W'(MAX_SHIFT);

    // One-lane step: lane k takes lane k+1, the top lane takes the fill value.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi == LANES - 1) begin : g_top
                assign data_shifted[gi*LANE_W +: LANE_W] = fill_reg;
            end else begin : g_low
                assign data_shifted[gi*LANE_W +: LANE_W] = data_reg[(gi+1)*LANE_W +: LANE_W];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (shift_illegal || shift == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (count_reg == SHIFT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // Illegal shifts capture the word untouched and go straight to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            count_reg <= '0;
            fill_reg  <= '0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            data_reg  <= in;
            count_reg <= shift;
            fill_reg  <= fill;
            err_reg   <= shift_illegal;
        end else if (state_reg == SHIFT) begin
            data_reg  <= data_shifted;
            count_reg <= count_reg - SHIFT_W'(1);
        end
    end

    assign out     = data_reg;
    assign out_err = err_reg;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: latency, lane results, errors,
// backpressure, asynchronous reset abort and a back-to-back stream.
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic [2:0]  shift;
    logic [11:0] fill;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out;
    logic        out_err;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [95:0] RAMP = 96'h008007006005004003002001;

    shift_right_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .shift     (shift),
        .fill      (fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] ref_shift(input logic [95:0] d, input int s, input logic [11:0] f);
        logic [95:0] r;
        for (int k = 0; k < 8; k++) begin
            if (k + s < 8) r[12*k +: 12] = d[12*(k+s) +: 12];
            else           r[12*k +: 12] = f;
        end
        return r;
    endfunction

    // Presents one request, corrupts the inputs after accept, and returns once
    // out_valid is seen (or the cycle budget runs out). lat counts edges from accept.
    task automatic run_req(input logic [95:0] d, input logic [2:0] s, input logic [11:0] f, output int lat);
        @(posedge clk); #1;
        in_data = d; shift = s; fill = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = ~d; shift = 3'd7; fill = ~f;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("req shift=%0d fill=%h out=%h err=%b lat=%0d", s, f, out, out_err, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; shift = '0; fill = '0;
        #12;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (out !== 96'h0) $display("FAIL reset_out got %h expected 0", out); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL reset_out_err got %b expected 0", out_err); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_legal_shift();
        int lat;
        out_ready = 1'b1;
        run_req(RAMP, 3'd2, 12'hABC, lat);
        n_checks++; if (out !== 96'hABCABC008007006005004003) $display("FAIL legal_out got %h expected %h", out, 96'hABCABC008007006005004003); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL legal_err got %b expected 0", out_err); else n_pass++;
        n_checks++; if (lat != 3) $display("FAIL legal_latency got %0d expected 3", lat); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_max_shift();
        int lat;
        run_req(RAMP, 3'd0, 12'h777, lat);
        n_checks++; if (out !== RAMP) $display("FAIL zero_out got %h expected %h", out, RAMP); else n_pass++;
        n_checks++; if (lat != 1) $display("FAIL zero_latency got %0d expected 1", lat); else n_pass++;
        @(posedge clk); #1;
        run_req(RAMP, 3'd5, 12'h00F, lat);
        n_checks++; if (out !== 96'h00F00F00F00F00F008007006) $display("FAIL max_out got %h expected %h", out, 96'h00F00F00F00F00F008007006); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL max_err got %b expected 0", out_err); else n_pass++;
        n_checks++; if (lat != 6) $display("FAIL max_latency got %0d expected 6", lat); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_shift();
        int lat;
        for (int s = 6; s <= 7; s++) begin
            run_req(96'h123456789ABCDEF012345678, 3'(s), 12'hFFF, lat);
            n_checks++; if (out !== 96'h123456789ABCDEF012345678) $display("FAIL illegal%0d_out got %h expected %h", s, out, 96'h123456789ABCDEF012345678); else n_pass++;
            n_checks++; if (out_err !== 1'b1) $display("FAIL illegal%0d_err got %b expected 1", s, out_err); else n_pass++;
            n_checks++; if (lat != 1) $display("FAIL illegal%0d_latency got %0d expected 1", s, lat); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        run_req(RAMP, 3'd1, 12'h555, lat);
        n_checks++; if (lat != 2) $display("FAIL bp_latency got %0d expected 2", lat); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid got %b expected 1", out_valid); else n_pass++;
            n_checks++; if (out !== 96'h555008007006005004003002) $display("FAIL bp_hold_out got %h expected %h", out, 96'h555008007006005004003002); else n_pass++;
            n_checks++; if (out_err !== 1'b0) $display("FAIL bp_hold_err got %b expected 0", out_err); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b expected 0", in_ready); else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        @(posedge clk); #1;
        in_data = RAMP; shift = 3'd5; fill = 12'hEEE; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (out !== 96'h0) $display("FAIL rst_mid_out got %h expected 0", out); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b expected 1", in_ready); else n_pass++;
        run_req(RAMP, 3'd1, 12'h555, lat);
        n_checks++; if (out !== 96'h555008007006005004003002) $display("FAIL rst_after_out got %h expected %h", out, 96'h555008007006005004003002); else n_pass++;
        n_checks++; if (lat != 2) $display("FAIL rst_after_latency got %0d expected 2", lat); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [95:0] d[4];
        logic [2:0]  s[4];
        logic [11:0] f[4];
        logic [95:0] expv;
        int idx_in = 0;
        int idx_out = 0;
        int cyc = 0;
        logic was_ready;
        for (int i = 0; i < 4; i++) begin
            d[i] = {$urandom, $urandom, $urandom};
            s[i] = 3'($urandom_range(5, 0));
            f[i] = 12'($urandom);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_data = d[0]; shift = s[0]; fill = f[0]; in_valid = 1'b1;
        was_ready = in_ready;
        while (idx_out < 4 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (was_ready && in_valid) begin
                n_checks++; if (idx_in != idx_out) $display("FAIL b2b_accept_busy got pending=%0d expected 0", idx_in - idx_out); else n_pass++;
                idx_in++;
                if (idx_in < 4) begin
                    in_data = d[idx_in]; shift = s[idx_in]; fill = f[idx_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                expv = ref_shift(d[idx_out], int'(s[idx_out]), f[idx_out]);
                $display("b2b req %0d shift=%0d out=%h err=%b", idx_out, s[idx_out], out, out_err);
                n_checks++; if (out !== expv) $display("FAIL b2b_out%0d got %h expected %h", idx_out, out, expv); else n_pass++;
                n_checks++; if (out_err !== 1'b0) $display("FAIL b2b_err%0d got %b expected 0", idx_out, out_err); else n_pass++;
                idx_out++;
            end
            was_ready = in_ready;
        end
        n_checks++; if (idx_out != 4) $display("FAIL b2b_complete got %0d expected 4", idx_out); else n_pass++;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_legal_shift();
        test_zero_max_shift();
        test_illegal_shift();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
